// File: rtl/fifo_arb_pkg.sv
// Shared types, default parameters and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_MAX_BURST  = 4;
   localparam int MAX_NUM_REQ    = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   // Index width stays at least 1 bit so a 1-entry range still has a legal vector.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int max_burst);
      return $clog2(max_burst) + 1;
   endfunction

   function automatic logic [MAX_NUM_REQ-1:0] onehot(input logic [2:0] idx);
      logic [MAX_NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0]   cand [NUM_REQ];
   logic [NUM_REQ-1:0] cand_req;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         logic [IDX_W:0] sum;
         assign sum          = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
         assign cand[gi]     = (sum >= (IDX_W+1)'(NUM_REQ))
                               ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                               : sum[IDX_W-1:0];
         assign cand_req[gi] = req[cand[gi]];
      end
   endgenerate

   // Scan from the far end so the candidate closest to the pointer wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_req[k]) begin
            found = 1'b1;
            idx   = cand[k];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bursts capped at MAX_BURST.
// Optional FIFO_ARB_STALL_CNT_EN adds a saturating stall_cnt output counting full-blocked burst cycles.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_BURST  = DEF_MAX_BURST
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
   input  logic                          fifo_full,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            ack,
   output logic                          fifo_w_en,
   output logic [DATA_WIDTH-1:0]         fifo_wdata
`ifdef FIFO_ARB_STALL_CNT_EN
   ,
   output logic [15:0]                   stall_cnt
`endif
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int CNT_W = cnt_width(MAX_BURST);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   state_e             state_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic [NUM_REQ-1:0] gnt_d;
   logic [IDX_W-1:0]   owner_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [IDX_W-1:0]   rr_ptr_d;
   logic [CNT_W-1:0]   beat_cnt_q;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic               in_burst;
   logic               owner_req;
   logic               accept;
   logic               burst_end;

   logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign wdata_arr[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .found   (pick_found),
      .idx     (pick_idx)
   );

   assign in_burst  = (state_q == BURST);
   assign owner_req = req[owner_q];
   // A write is suppressed in the reset cycle even though the registered owner is still valid.
   assign accept    = in_burst & owner_req & ~fifo_full & ~rst;
   assign burst_end = in_burst & (~owner_req |
                                  (accept & (last[owner_q] | (beat_cnt_q == LAST_BEAT))));

   assign gnt_d    = NUM_REQ'(onehot(3'(pick_idx)));
   assign rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  state_q    <= BURST;
                  gnt_q      <= gnt_d;
                  owner_q    <= pick_idx;
                  beat_cnt_q <= '0;
               end
            end
            BURST: begin
               if (burst_end) begin
                  state_q  <= IDLE;
                  gnt_q    <= '0;
                  rr_ptr_q <= rr_ptr_d;
               end else if (accept) begin
                  beat_cnt_q <= beat_cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign gnt        = gnt_q;
   assign ack        = accept ? gnt_q : '0;
   assign fifo_w_en  = accept;
   assign fifo_wdata = accept ? wdata_arr[owner_q] : '0;

`ifdef FIFO_ARB_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (in_burst && owner_req && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
